// File: rtl/pc_sequencer_if.sv
// Handshake and strobe bundle between pc_sequencer (master) and the memories/datapath (slave).
// Requests and strobes flow out of the master; acks, decode info and redirects flow in.
interface pc_sequencer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic             run;
    logic             imem_ack;
    logic             dm_ack;
    logic             is_mem_op;
    logic             redirect;
    logic [XLEN-1:0]  redirect_target;
    logic [XLEN-1:0]  pc;
    logic             imem_req;
    logic             rf_rd_en;
    logic             exec_en;
    logic             dm_req;
    logic             wb_en;
    logic             halted;
    logic [1:0]       status;
    logic [CNT_W-1:0] retired;
    logic [31:0]      tx_word;

    modport master (
        input  run, imem_ack, dm_ack, is_mem_op, redirect, redirect_target,
        output pc, imem_req, rf_rd_en, exec_en, dm_req, wb_en, halted, status, retired, tx_word
    );

    modport slave (
        output run, imem_ack, dm_ack, is_mem_op, redirect, redirect_target,
        input  pc, imem_req, rf_rd_en, exec_en, dm_req, wb_en, halted, status, retired, tx_word
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle FETCH/READ/EXEC/MEM/WB sequencer owning the PC, with pass/fail halt detection.
// 4 cycles per instruction minimum (5 with memory); FETCH and MEM wait on their acks, run=0 stalls in FETCH.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
    parameter logic [XLEN-1:0] PASS_ADDR    = XLEN'(32'h8000_06AC),
    parameter logic [XLEN-1:0] FAIL_ADDR    = XLEN'(32'h8000_0690),
    parameter int unsigned     CNT_W        = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        FETCH,
        READ,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [1:0]       status_q, status_d;
    logic             halted_q, halted_d;
    logic [31:0]      tx_word_q, tx_word_d;
    logic             hit;
    logic             imem_req;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [31:0] hex16(input logic [15:0] v);
        return {hex_char(v[15:12]), hex_char(v[11:8]), hex_char(v[7:4]), hex_char(v[3:0])};
    endfunction

    assign hit      = (pc_q == PASS_ADDR) || (pc_q == FAIL_ADDR);
    assign imem_req = (state_q == FETCH) && bus.run && !hit;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        status_d  = status_q;
        halted_d  = halted_q;

        case (state_q)
            FETCH: begin
                // End-of-test check takes priority over fetching, even when paused.
                if (hit) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                    status_d = (pc_q == PASS_ADDR) ? 2'b01 : 2'b10;
                end else if (imem_req && bus.imem_ack) begin
                    state_d = READ;
                end
            end
            READ:    state_d = EXEC;
            EXEC:    state_d = bus.is_mem_op ? MEM : WB;
            MEM:     if (bus.dm_ack) state_d = WB;
            WB: begin
                state_d   = FETCH;
                pc_d      = bus.redirect ? (bus.redirect_target & ~XLEN'(3)) : (pc_q + XLEN'(4));
                retired_d = retired_q + CNT_W'(1);
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase

        case (status_q)
            2'b01:   tx_word_d = "pass";
            2'b10:   tx_word_d = "fail";
            default: tx_word_d = hex16(pc_q[15:0]);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_VECTOR;
            retired_q <= '0;
            status_q  <= 2'b00;
            halted_q  <= 1'b0;
            tx_word_q <= hex16(RESET_VECTOR[15:0]);
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            status_q  <= status_d;
            halted_q  <= halted_d;
            tx_word_q <= tx_word_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.imem_req = imem_req;
    assign bus.rf_rd_en = (state_q == READ);
    assign bus.exec_en  = (state_q == EXEC);
    assign bus.dm_req   = (state_q == MEM);
    assign bus.wb_en    = (state_q == WB);
    assign bus.halted   = halted_q;
    assign bus.status   = status_q;
    assign bus.retired  = retired_q;
    assign bus.tx_word  = tx_word_q;
endmodule
